reqrsp_responder: RTL and testbench

Hardware responder for the 32-bit valid/ready request/response channel: it terminates the request side that an initiator (or a Python-driven TLM initiator through the pyhdl-if bridge) drives, and returns exactly one response per request, in order. Each response is the request word plus a fixed increment, delayed by a fixed pipeline latency and buffered under credit-based flow control. It sits where a loopback would otherwise close the channel, so benches can check a real responder with back-pressure.

---
 rtl/reqrsp_responder.sv | 141 ++++++++++++++
 tb/tb_reqrsp_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reqrsp_responder.sv
// Request/response responder: returns req_data + INCR for every accepted request, in order,
// after LATENCY cycles, with credit-limited buffering. Optional counters: REQRSP_RESPONDER_STATS_EN.
module reqrsp_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4,
  parameter int INCR       = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data
`ifdef REQRSP_RESPONDER_STATS_EN
  ,
  output logic [31:0]           req_count,
  output logic [31:0]           rsp_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] INCR_W = DATA_WIDTH'(INCR);

  logic                  accept;
  logic                  deliver;
  logic [CNT_W-1:0]      inflight;
  logic [DATA_WIDTH-1:0] rsp_word;
  logic                  push_vld;
  logic [DATA_WIDTH-1:0] push_dat;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit decode uses registered inflight only, so a pop never raises ready in the same cycle.
  assign req_ready = !reset && (inflight < CNT_W'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fifo_cnt != '0);
  assign deliver   = rsp_valid && rsp_ready;
  assign rsp_data  = mem[rd_ptr];
  assign rsp_word  = req_data + INCR_W;

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({accept, deliver})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push_vld = accept;
      assign push_dat = rsp_word;
    end else begin : g_pipe
      logic [LATENCY-2:0]    pipe_vld;
      logic [DATA_WIDTH-1:0] pipe_dat [LATENCY-1];

      always_ff @(posedge clock) begin
        if (reset) begin
          pipe_vld <= '0;
        end else begin
          pipe_vld[0] <= accept;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
          end
        end
      end

      // Data stages only load behind a valid bit; no reset needed on payload.
      always_ff @(posedge clock) begin
        if (accept) begin
          pipe_dat[0] <= rsp_word;
        end
        for (int i = 1; i < LATENCY - 1; i++) begin
          if (pipe_vld[i-1]) begin
            pipe_dat[i] <= pipe_dat[i-1];
          end
        end
      end

      assign push_vld = pipe_vld[LATENCY-2];
      assign push_dat = pipe_dat[LATENCY-2];
    end
  endgenerate

  // Credit accounting guarantees a push never finds the FIFO full unless it also pops.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (deliver) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_vld, deliver})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef REQRSP_RESPONDER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      req_count <= '0;
      rsp_count <= '0;
    end else begin
      if (accept) begin
        req_count <= req_count + 32'd1;
      end
      if (deliver) begin
        rsp_count <= rsp_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reqrsp_responder.sv
// Directed bench for reqrsp_responder (defaults LATENCY=2, DEPTH=4, INCR=1) with a cycle-level
// reference model of the credit/latency behaviour; counter checks when REQRSP_RESPONDER_STATS_EN is set.
module tb_reqrsp_responder;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
`ifdef REQRSP_RESPONDER_STATS_EN
  logic [31:0] req_count;
  logic [31:0] rsp_count;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] m_fifo[$];
  logic        m_pv;
  logic [31:0] m_pd;
  int          m_inflight;
  int          m_reqc;
  int          m_rspc;
  int          dut_acc;
  int          dut_del;
  int          rdy_drops;

  reqrsp_responder dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
`ifdef REQRSP_RESPONDER_STATS_EN
    ,
    .req_count (req_count),
    .rsp_count (rsp_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare the DUT state just after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic rr);
    logic acc;
    logic del;
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    acc = !reset && v && (m_inflight < 4);
    del = !reset && (m_fifo.size() > 0) && rr;
    if (req_valid && req_ready) dut_acc++;
    if (rsp_valid && rsp_ready) dut_del++;
    if (!req_ready && !reset) rdy_drops++;
    @(posedge clock);
    #1;
    if (reset) begin
      m_fifo.delete();
      m_pv       = 1'b0;
      m_inflight = 0;
      m_reqc     = 0;
      m_rspc     = 0;
    end else begin
      if (del) void'(m_fifo.pop_front());
      if (m_pv) m_fifo.push_back(m_pd);
      m_pv       = acc;
      m_pd       = d + 32'd1;
      m_inflight = m_inflight + int'(acc) - int'(del);
      m_reqc     = m_reqc + int'(acc);
      m_rspc     = m_rspc + int'(del);
    end
    check("req_ready", {31'd0, req_ready}, {31'd0, !reset && (m_inflight < 4)});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_fifo.size() > 0});
    if (m_fifo.size() > 0) check("rsp_data", rsp_data, m_fifo[0]);
    else if (reset)        check("rsp_data_rst", rsp_data, 32'd0);
`ifdef REQRSP_RESPONDER_STATS_EN
    check("req_count", req_count, m_reqc);
    check("rsp_count", rsp_count, m_rspc);
`endif
  endtask

  initial begin
    int a0;
    int d0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_data   = '0;
    rsp_ready  = 1'b0;
    m_pv       = 1'b0;
    m_pd       = '0;
    m_inflight = 0;
    m_reqc     = 0;
    m_rspc     = 0;
    dut_acc    = 0;
    dut_del    = 0;
    rdy_drops  = 0;

    // Reset state.
    repeat (3) step(1'b1, 32'h1234, 1'b1);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    check("first_ready", {31'd0, req_ready}, 32'd1);

    // Single request: 0x10 -> 0x11, valid after E0+1, delivered at E0+2.
    d0 = dut_del;
    step(1'b1, 32'h10, 1'b1);
    check("single_e0_valid", {31'd0, rsp_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("single_e1_valid", {31'd0, rsp_valid}, 32'd1);
    check("single_e1_data", rsp_data, 32'h11);
    step(1'b0, 32'h0, 1'b1);
    check("single_delivered", dut_del - d0, 32'd1);
    check("single_e2_valid", {31'd0, rsp_valid}, 32'd0);

    // Wrap of the increment.
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    check("wrap_data", rsp_data, 32'h0000_0000);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Back-pressure: six offers, four accepted, responses 2..5.
    a0 = dut_acc;
    for (int i = 1; i <= 6; i++) step(1'b1, i, 1'b0);
    check("bp_accepted", dut_acc - a0, 32'd4);
    check("bp_full_ready", {31'd0, req_ready}, 32'd0);
    step(1'b0, 32'h0, 1'b0);
    check("bp_head_stable", rsp_data, 32'd2);
    step(1'b0, 32'h0, 1'b1);
    check("bp_ready_after_pop", {31'd0, req_ready}, 32'd1);
    check("bp_second", rsp_data, 32'd3);
    step(1'b0, 32'h0, 1'b1);
    check("bp_third", rsp_data, 32'd4);
    step(1'b0, 32'h0, 1'b1);
    check("bp_fourth", rsp_data, 32'd5);
    step(1'b0, 32'h0, 1'b1);
    check("bp_drained", {31'd0, rsp_valid}, 32'd0);

    // Streaming 0..99 with rsp_ready high.
    d0 = dut_del;
    rdy_drops = 0;
    for (int i = 0; i < 100; i++) step(1'b1, i, 1'b1);
    check("stream_ready_drops", rdy_drops, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("stream_last", {31'd0, rsp_valid}, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    check("stream_delivered", dut_del - d0, 32'd100);

    // Random back-pressure with continuous model comparison.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);
    check("rand_balance", dut_acc, dut_del);

    // Reset with three requests in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + i, 1'b0);
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    d0 = dut_del;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    check("midrst_no_stale", dut_del - d0, 32'd0);

`ifdef REQRSP_RESPONDER_STATS_EN
    check("stats_zero_req", req_count, 32'd0);
    check("stats_zero_rsp", rsp_count, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
    end
    check("stats_five_req", req_count, 32'd5);
    check("stats_five_rsp", rsp_count, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
